float_to_int: RTL and testbench
===============================

Name: float_to_int

Overview:
- Converts IEEE-754 single-precision values to signed OUT_W-bit integers, round-to-nearest-even, saturating.
- Used on the return path of the JPEG datapath, where float DCT/quantiser results are turned back into integer coefficients for entropy coding. It is the inverse of the int8-to-float front end.
- Two-stage pipeline with valid/ready backpressure on both sides, per-word status flags, and a saturation event counter.

Parameters:
- OUT_W, 8, output integer width; legal range 2..24.
- SAT_CNT_W, 16, width of the saturation event counter.

Ports:
- clk  input  1  clock.
- nrst  input  1  asynchronous active-low reset.
- din  input  32  float32 operand {sign, exp[7:0], man[22:0]}.
- din_valid  input  1  din is valid.
- din_ready  output  1  block accepts din this cycle.
- dout  output  OUT_W  two's-complement result.
- dout_valid  output  1  dout and the flags are valid.
- dout_ready  input  1  downstream accepts dout.
- dout_sat  output  1  result was clamped (overflow or Inf).
- dout_nan  output  1  input was NaN; dout is 0.
- clr_count  input  1  synchronous clear of sat_count.
- sat_count  output  SAT_CNT_W  number of accepted saturated outputs; sticks at its maximum value.

Behaviour:
- Reset values: dout_valid=0, dout=0, dout_sat=0, dout_nan=0, sat_count=0, internal s1_valid=0.
- Both stage valids clear asynchronously, which drops any in-flight words.
- Handshake:
  - s2 advances when ~dout_valid | dout_ready.
  - s1 advances when ~s1_valid | s2 advances.
  - din_ready equals the s1 advance term; a transfer occurs when din_valid & din_ready.
  - Latency is 2 cycles from acceptance to dout_valid. Full throughput is 1 word/cycle.
  - dout and the flags hold stable while dout_valid & ~dout_ready.
- Stage 1 (classify and align):
  - Input classes:
    - exp=0: zero, including denormals, which flush to zero.
    - exp=255 with man!=0: NaN.
    - exp=255 with man=0: Inf.
    - otherwise: normal.
  - Compute e = exp-127 as a signed value, and M = {1, man} (24 bits).
  - e < -1: int=0, guard=0, sticky=0.
  - e = -1: int=0, guard=1, sticky=(man!=0).
  - 0 <= e <= 22: int = M >> (23-e); guard = M[22-e]; sticky = OR of M[21-e:0].
  - e = 23: int=M, guard=0, sticky=0.
  - Flag ovf when e >= OUT_W.
  - Register sign, class, int (OUT_W+1 bits, truncated after the ovf check), guard, sticky, ovf.
- Stage 2 (round and saturate):
  - Round to nearest even: round_up = guard & (sticky | int[0]); mag = int + round_up, kept at OUT_W+1 bits.
  - Limits are MAX = 2^(OUT_W-1)-1 and MIN = -2^(OUT_W-1).
  - Positive sign: saturate when ovf | Inf | mag > MAX. Result MAX, sat=1.
  - Negative sign: saturate when ovf | Inf | mag > 2^(OUT_W-1). Result MIN, sat=1.
  - Negative mag equal to 2^(OUT_W-1) yields MIN with sat=0.
  - NaN: dout=0, nan=1, sat=0.
  - Zero, including -0.0: dout=0, both flags 0.
  - Otherwise dout = sign ? -mag : mag.
- Counter:
  - Increments when dout_valid & dout_ready & dout_sat, unless it is already all-ones.
  - clr_count takes priority over a simultaneous increment (result 0).

Decomposition:
- Package float_pkg holds:
  - constants FP_BIAS=127, FP_EXP_W=8, FP_MAN_W=23;
  - typedef fp32_t, a packed struct {sign, exp, man};
  - enum fp_class_t {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN}.
- One sub-module, fp_align: combinational right shift of M by e, producing int, guard, sticky and ovf. It is instantiated in stage 1.
- Rounding, saturation and the handshake stay in the top level.

Test Plan:
- Rounding, OUT_W=8:
  - 0x3FC00000 (1.5) -> 0x02.
  - 0x40200000 (2.5) -> 0x02.
  - 0xBFC00000 (-1.5) -> 0xFE.
  - 0x3F000000 (0.5) -> 0x00.
  - 0x3F400000 (0.75) -> 0x01.
  - All with flags 0 and 2-cycle latency.
- Saturation:
  - 0x43000000 (128.0) -> 0x7F, sat=1.
  - 0x42FF0000 (127.5) -> 0x7F, sat=1.
  - 0xC3000000 (-128.0) -> 0x80, sat=0.
  - 0xC3010000 (-129.0) -> 0x80, sat=1.
  - 0x7F800000 (+Inf) -> 0x7F, sat=1.
- Specials:
  - 0x7FC00000 (NaN) -> 0x00, nan=1.
  - 0x00000001 (denormal) -> 0x00.
  - 0x80000000 (-0.0) -> 0x00, both flags 0.
- Backpressure:
  - Stream 1.0, 2.0, 3.0, 4.0 back-to-back with dout_ready=0 for 3 cycles after the first dout_valid.
  - din_ready drops once two words are buffered.
  - dout holds 0x01 stable while stalled; then 0x01, 0x02, 0x03, 0x04 are delivered in order with no loss or duplication.
- Counter, with SAT_CNT_W=4:
  - 20 accepted saturating words -> sat_count=15.
  - clr_count asserted in the same cycle as a saturated acceptance -> sat_count=0.
  - A saturated word held with dout_ready=0 does not count.
- Reset mid-stream: assert nrst low with both stages full -> dout_valid=0 and sat_count=0 immediately; after release, the first new input appears 2 cycles after acceptance.

Source files
------------

// File: rtl/float_pkg.sv
// Shared float32 field layout, class encoding and bias constants for the
// float-to-integer return path.
package float_pkg;

  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_t;

  // Denormals are grouped with zero so they flush to 0 downstream.
  function automatic fp_class_t fp_classify(input fp32_t f);
    fp_class_t c;
    if (f.exp == '0)
      c = FP_ZERO;
    else if (f.exp == '1)
      c = (f.man != '0) ? FP_NAN : FP_INF;
    else
      c = FP_NORMAL;
    return c;
  endfunction

endpackage

// File: rtl/fp_align.sv
// Aligns the 24-bit significand by the unbiased exponent: integer part,
// round guard/sticky bits and an overflow flag for the target width.
module fp_align
  import float_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic [FP_MAN_W-1:0] man,
  input  logic signed [9:0]   e,
  output logic [OUT_W:0]      int_val,
  output logic                guard,
  output logic                sticky,
  output logic                ovf
);

  logic [FP_MAN_W:0]       m_full;
  logic [2*FP_MAN_W+1:0]   shifted;
  logic [4:0]              amt;

  // The significand sits in the upper half of a 48-bit window; after the
  // shift the upper half is the integer part and the lower half the fraction.
  always_comb begin
    m_full  = {1'b1, man};
    amt     = '0;
    shifted = '0;
    int_val = '0;
    guard   = 1'b0;
    sticky  = 1'b0;
    if (e >= -10'sd1 && e <= 10'sd23) begin
      amt     = 5'(10'sd23 - e);
      shifted = {m_full, 24'b0} >> amt;
      int_val = (OUT_W+1)'(shifted[47:24]);
      guard   = shifted[23];
      sticky  = |shifted[22:0];
    end else if (e > 10'sd23) begin
      int_val = (OUT_W+1)'(m_full);
    end
    ovf = (e >= $signed(10'(OUT_W)));
  end

endmodule

// File: rtl/float_to_int.sv
// float32 -> signed OUT_W integer, round-to-nearest-even, saturating, with a
// 2-stage valid/ready pipeline and a sticky saturation event counter.
module float_to_int
  import float_pkg::*;
#(
  parameter int OUT_W     = 8,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [31:0]          din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [OUT_W-1:0]     dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_sat,
  output logic                 dout_nan,
  input  logic                 clr_count,
  output logic [SAT_CNT_W-1:0] sat_count
);

  localparam logic [OUT_W:0]   POS_MAX = (OUT_W+1)'((2**(OUT_W-1)) - 1);
  localparam logic [OUT_W:0]   NEG_MAG = (OUT_W+1)'(2**(OUT_W-1));
  localparam logic [OUT_W-1:0] RES_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] RES_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  fp32_t             f_in;
  logic signed [9:0] in_e;
  logic [OUT_W:0]    a_int;
  logic              a_guard, a_sticky, a_ovf;
  logic              s1_adv, s2_adv;

  logic              s1_valid_d, s1_valid_q, s1_sign_d, s1_sign_q;
  fp_class_t         s1_class_d, s1_class_q;
  logic [OUT_W:0]    s1_int_d, s1_int_q;
  logic              s1_guard_d, s1_guard_q, s1_sticky_d, s1_sticky_q;
  logic              s1_ovf_d, s1_ovf_q;

  logic                 dout_valid_d, dout_valid_q;
  logic [OUT_W-1:0]     dout_d, dout_q;
  logic                 dout_sat_d, dout_sat_q, dout_nan_d, dout_nan_q;
  logic [SAT_CNT_W-1:0] sat_count_d, sat_count_q;

  logic              round_up, is_sat;
  logic [OUT_W:0]    mag;

  assign f_in = fp32_t'(din);
  assign in_e = $signed({2'b00, f_in.exp}) - $signed(10'(FP_BIAS));

  fp_align #(.OUT_W(OUT_W)) u_align (
    .man     (f_in.man),
    .e       (in_e),
    .int_val (a_int),
    .guard   (a_guard),
    .sticky  (a_sticky),
    .ovf     (a_ovf)
  );

  assign s2_adv    = ~dout_valid_q | dout_ready;
  assign s1_adv    = ~s1_valid_q | s2_adv;
  assign din_ready = s1_adv;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_class_d  = s1_class_q;
    s1_int_d    = s1_int_q;
    s1_guard_d  = s1_guard_q;
    s1_sticky_d = s1_sticky_q;
    s1_ovf_d    = s1_ovf_q;
    if (s1_adv) begin
      s1_valid_d  = din_valid;
      s1_sign_d   = f_in.sign;
      s1_class_d  = fp_classify(f_in);
      s1_int_d    = a_int;
      s1_guard_d  = a_guard;
      s1_sticky_d = a_sticky;
      s1_ovf_d    = a_ovf;
    end
  end

  // Negative magnitudes may reach exactly 2^(OUT_W-1) without clamping.
  always_comb begin
    round_up     = s1_guard_q & (s1_sticky_q | s1_int_q[0]);
    mag          = s1_int_q + (OUT_W+1)'(round_up);
    is_sat       = 1'b0;
    dout_valid_d = dout_valid_q;
    dout_d       = dout_q;
    dout_sat_d   = dout_sat_q;
    dout_nan_d   = dout_nan_q;
    if (s2_adv) begin
      dout_valid_d = s1_valid_q;
      dout_d       = '0;
      dout_sat_d   = 1'b0;
      dout_nan_d   = 1'b0;
      case (s1_class_q)
        FP_NAN:  dout_nan_d = 1'b1;
        FP_ZERO: dout_d = '0;
        default: begin
          if (s1_sign_q) begin
            is_sat = s1_ovf_q | (s1_class_q == FP_INF) | (mag > NEG_MAG);
            dout_d = is_sat ? RES_MIN : OUT_W'(-mag);
          end else begin
            is_sat = s1_ovf_q | (s1_class_q == FP_INF) | (mag > POS_MAX);
            dout_d = is_sat ? RES_MAX : OUT_W'(mag);
          end
          dout_sat_d = is_sat;
        end
      endcase
    end
  end

  always_comb begin
    sat_count_d = sat_count_q;
    if (clr_count)
      sat_count_d = '0;
    else if (dout_valid_q & dout_ready & dout_sat_q & ~&sat_count_q)
      sat_count_d = sat_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_class_q   <= FP_ZERO;
      s1_int_q     <= '0;
      s1_guard_q   <= 1'b0;
      s1_sticky_q  <= 1'b0;
      s1_ovf_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      dout_sat_q   <= 1'b0;
      dout_nan_q   <= 1'b0;
      sat_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_class_q   <= s1_class_d;
      s1_int_q     <= s1_int_d;
      s1_guard_q   <= s1_guard_d;
      s1_sticky_q  <= s1_sticky_d;
      s1_ovf_q     <= s1_ovf_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      dout_sat_q   <= dout_sat_d;
      dout_nan_q   <= dout_nan_d;
      sat_count_q  <= sat_count_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign dout_sat   = dout_sat_q;
  assign dout_nan   = dout_nan_q;
  assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_float_to_int.sv
// Directed bench for float_to_int: arithmetic reference model plus scoreboard,
// with literal expectations for rounding, saturation, backpressure and reset.
module tb_float_to_int;

  localparam int OUT_W     = 8;
  localparam int SAT_CNT_W = 4;

  logic                 clk = 1'b0;
  logic                 nrst;
  logic [31:0]          din;
  logic                 din_valid, din_ready;
  logic [OUT_W-1:0]     dout;
  logic                 dout_valid, dout_ready, dout_sat, dout_nan;
  logic                 clr_count;
  logic [SAT_CNT_W-1:0] sat_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [OUT_W-1:0] d;
    bit               sat;
    bit               nan;
  } exp_t;

  typedef struct {
    logic [31:0]      f;
    logic [OUT_W-1:0] d;
    bit               sat;
    bit               nan;
  } vec_t;

  exp_t exp_q[$];
  int   cnt_m = 0;

  float_to_int #(.OUT_W(OUT_W), .SAT_CNT_W(SAT_CNT_W)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_sat   (dout_sat),
    .dout_nan   (dout_nan),
    .clr_count  (clr_count),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Exact-value reference: floor by division, then compare the remainder
  // against one half to pick the nearest (ties to even), then clamp.
  function automatic void model(input logic [31:0] f, output logic [OUT_W-1:0] d,
                                output bit sat, output bit nan);
    longint mant, q, rem, half, v, lim_hi, lim_lo;
    int ex, sh;
    ex     = int'(f[30:23]);
    mant   = longint'(f[22:0]) + (longint'(1) << 23);
    lim_hi = (longint'(1) << (OUT_W-1)) - 1;
    lim_lo = -(longint'(1) << (OUT_W-1));
    d = '0; sat = 0; nan = 0;
    if (ex == 255) begin
      if (f[22:0] != 0) nan = 1;
      else begin
        sat = 1;
        d = f[31] ? OUT_W'(lim_lo) : OUT_W'(lim_hi);
      end
      return;
    end
    if (ex == 0) return;
    sh = 150 - ex;
    if (sh < -20) q = longint'(1) << 50;
    else if (sh <= 0) q = mant << (-sh);
    else if (sh > 40) q = 0;
    else begin
      q    = mant >> sh;
      rem  = mant - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end
    v = f[31] ? -q : q;
    if (v > lim_hi) begin d = OUT_W'(lim_hi); sat = 1; end
    else if (v < lim_lo) begin d = OUT_W'(lim_lo); sat = 1; end
    else d = OUT_W'(v);
  endfunction

  // Scoreboard: every cycle with dout_valid must match the oldest accepted word.
  always @(negedge clk) begin
    exp_t e;
    bit   popped_sat;
    if (!nrst) begin
      exp_q.delete();
      cnt_m = 0;
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_sat_count", sat_count, 0);
    end else begin
      chk("sat_count", sat_count, cnt_m);
      popped_sat = 0;
      if (dout_valid) begin
        if (exp_q.size() == 0) chk("unexpected_dout", 1, 0);
        else begin
          chk("sb_dout", dout, exp_q[0].d);
          chk("sb_sat", dout_sat, exp_q[0].sat);
          chk("sb_nan", dout_nan, exp_q[0].nan);
          if (dout_ready) begin
            popped_sat = exp_q[0].sat;
            void'(exp_q.pop_front());
          end
        end
      end
      if (clr_count) cnt_m = 0;
      else if (popped_sat && cnt_m != (1 << SAT_CNT_W) - 1) cnt_m++;
      if (din_valid && din_ready) begin
        model(din, e.d, e.sat, e.nan);
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dout(input string name);
    int n = 0;
    while (!dout_valid && n < 10) begin tick(); n++; end
    if (!dout_valid) chk(name, 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [OUT_W-1:0] md;
    bit ms, mn;
    int lat = 0;
    model(v.f, md, ms, mn);
    chk("model_dout", md, v.d);
    chk("model_sat", ms, v.sat);
    chk("model_nan", mn, v.nan);
    din = v.f;
    din_valid = 1;
    do begin
      tick();
      lat++;
      if (lat == 1) din_valid = 0;
    end while (!dout_valid && lat < 8);
    chk("latency", lat, 2);
    chk("vec_dout", dout, v.d);
    chk("vec_sat", dout_sat, v.sat);
    chk("vec_nan", dout_nan, v.nan);
    tick();
  endtask

  vec_t vecs[13] = '{
    '{32'h3FC00000, 8'h02, 0, 0},
    '{32'h40200000, 8'h02, 0, 0},
    '{32'hBFC00000, 8'hFE, 0, 0},
    '{32'h3F000000, 8'h00, 0, 0},
    '{32'h3F400000, 8'h01, 0, 0},
    '{32'h43000000, 8'h7F, 1, 0},
    '{32'h42FF0000, 8'h7F, 1, 0},
    '{32'hC3000000, 8'h80, 0, 0},
    '{32'hC3010000, 8'h80, 1, 0},
    '{32'h7F800000, 8'h7F, 1, 0},
    '{32'h7FC00000, 8'h00, 0, 1},
    '{32'h00000001, 8'h00, 0, 0},
    '{32'h80000000, 8'h00, 0, 0}
  };

  logic [31:0] bp_words[4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

  initial begin
    nrst = 0; din = '0; din_valid = 0; dout_ready = 1; clr_count = 0;
    #2;
    chk("reset_dout_valid", dout_valid, 0);
    chk("reset_dout", dout, 0);
    chk("reset_dout_sat", dout_sat, 0);
    chk("reset_dout_nan", dout_nan, 0);
    chk("reset_sat_count", sat_count, 0);
    chk("reset_din_ready", din_ready, 1);
    repeat (2) @(posedge clk);
    #1 nrst = 1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: four words back to back, output stalled 3 cycles.
    dout_ready = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int n = 0;
          @(posedge clk); #2;
          din = bp_words[i];
          din_valid = 1;
          while (!din_ready && n < 20) begin @(posedge clk); #2; n++; end
          if (!din_ready) chk("bp_accept_timeout", 0, 1);
        end
        @(posedge clk); #2;
        din_valid = 0;
      end
      begin
        logic [OUT_W-1:0] got[$];
        int m = 0;
        wait_dout("bp_first_valid_timeout");
        for (int k = 0; k < 3; k++) begin
          chk("bp_hold_dout", dout, 8'h01);
          chk("bp_din_ready_low", din_ready, 0);
          tick();
        end
        dout_ready = 1;
        while (got.size() < 4 && m < 20) begin
          if (dout_valid && dout_ready) got.push_back(dout);
          tick();
          m++;
        end
        chk("bp_count", got.size(), 4);
        foreach (got[i]) chk("bp_order", got[i], i + 1);
      end
    join
    repeat (3) tick();

    // Counter saturation, clear priority and stall behaviour.
    clr_count = 1; tick(); clr_count = 0;
    chk("cnt_clear", sat_count, 0);
    din = 32'h43000000;
    for (int i = 0; i < 20; i++) begin
      int n = 0;
      din_valid = 1;
      while (!din_ready && n < 10) begin tick(); n++; end
      tick();
    end
    din_valid = 0;
    repeat (4) tick();
    chk("cnt_sticky_max", sat_count, 15);

    din_valid = 1; tick(); din_valid = 0;
    wait_dout("cnt_clr_valid_timeout");
    clr_count = 1; tick(); clr_count = 0;
    chk("cnt_clr_priority", sat_count, 0);
    tick();

    dout_ready = 0;
    din_valid = 1; tick(); din_valid = 0;
    wait_dout("cnt_hold_valid_timeout");
    repeat (3) tick();
    chk("cnt_hold_no_count", sat_count, 0);
    dout_ready = 1; tick();
    chk("cnt_release_count", sat_count, 1);
    tick();

    // Reset with both stages holding data.
    dout_ready = 0;
    din = 32'h3F800000; din_valid = 1; tick();
    din = 32'h40000000; tick();
    din_valid = 0;
    chk("rst_pre_full_valid", dout_valid, 1);
    chk("rst_pre_full_ready", din_ready, 0);
    #2 nrst = 0;
    #1;
    chk("rst_async_valid", dout_valid, 0);
    chk("rst_async_count", sat_count, 0);
    @(posedge clk);
    #1 nrst = 1;
    dout_ready = 1;
    tick();
    run_vec('{32'h40400000, 8'h03, 0, 0});
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
